// File: rtl/if_fetch.sv
// Instruction fetch stage: 4-state request/wait/hold FSM with deferred branch redirect.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.

`ifndef IF_FETCH_DEFINES
`define IF_FETCH_DEFINES
`define StallBus 6
`define Stop 1'b1
`define NoStop 1'b0
`define BR_WD 33
`define IF_TO_ID_WD 33
`endif

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [`StallBus-1:0]    stall,
    input  logic [`BR_WD-1:0]       br_bus,
    output logic [`IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic [31:0]             inst_o,
    output logic                    inst_sram_req,
    output logic [31:0]             inst_sram_addr,
    input  logic                    inst_sram_addr_ok,
    input  logic                    inst_sram_data_ok,
    input  logic [31:0]             inst_sram_rdata,
    output logic                    stallreq_if
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]             perf_fetch_cnt,
    output logic [31:0]             perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_r;
    logic [31:0] next_pc;
    logic [31:0] inst_buf;
    logic [31:0] br_pend_addr;
    logic        br_pend_v;
    logic        br_e;
    logic [31:0] br_addr;
    logic        ce;
    logic        leave;
    logic        unused_stall;

    assign br_e         = br_bus[32];
    assign br_addr      = br_bus[31:0];
    assign unused_stall = ^stall[`StallBus-1:1];

    assign ce    = (state == HOLD);
    assign leave = ce && (stall[0] == `NoStop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: state_nx = REQ;
            REQ:  if (inst_sram_addr_ok) state_nx = WAIT;
            WAIT: if (inst_sram_data_ok) state_nx = HOLD;
            HOLD: if (leave) state_nx = REQ;
            default: state_nx = IDLE;
        endcase
    end

    // A branch seen in the leaving cycle beats any older pending target
    always_comb begin
        next_pc = pc_r + 32'd4;
        if (br_e) begin
            next_pc = br_addr;
        end else if (br_pend_v) begin
            next_pc = br_pend_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (leave) begin
            pc_r <= next_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_buf <= 32'd0;
        end else if (state == WAIT && inst_sram_data_ok) begin
            inst_buf <= inst_sram_rdata;
        end
    end

    // Redirects arriving mid-fetch are parked so the delay slot completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_pend_v    <= 1'b0;
            br_pend_addr <= 32'd0;
        end else if (leave) begin
            br_pend_v    <= 1'b0;
        end else if (br_e) begin
            br_pend_v    <= 1'b1;
            br_pend_addr <= br_addr;
        end
    end

    always_comb begin
        inst_sram_req  = (state == REQ);
        inst_sram_addr = pc_r;
        if_to_id_bus   = ce ? {1'b1, pc_r} : '0;
        inst_o         = ce ? inst_buf : 32'd0;
        stallreq_if    = !ce;
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (leave) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stallreq_if) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    // no performance counters in this build
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: SRAM responder, decode-side driver and fetch-order model.
// Build with IF_PERF_CNT_EN defined to also check the fetch counter.

`ifndef IF_FETCH_DEFINES
`define IF_FETCH_DEFINES
`define StallBus 6
`define Stop 1'b1
`define NoStop 1'b0
`define BR_WD 33
`define IF_TO_ID_WD 33
`endif

module tb_if_fetch;

    localparam logic [31:0] RP = 32'hBFC0_0000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [`StallBus-1:0]    stall;
    logic [`BR_WD-1:0]       br_bus;
    logic [`IF_TO_ID_WD-1:0] if_to_id_bus;
    logic [31:0]             inst_o;
    logic                    inst_sram_req;
    logic [31:0]             inst_sram_addr;
    logic                    inst_sram_addr_ok;
    logic                    inst_sram_data_ok;
    logic [31:0]             inst_sram_rdata;
    logic                    stallreq_if;
`ifdef IF_PERF_CNT_EN
    logic [31:0]             perf_fetch_cnt;
    logic [31:0]             perf_stall_cnt;
`endif

    if_fetch #(.RESET_PC(RP)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .br_bus           (br_bus),
        .if_to_id_bus     (if_to_id_bus),
        .inst_o           (inst_o),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata  (inst_sram_rdata),
        .stallreq_if      (stallreq_if)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // reference model: address of the instruction currently expected
    logic [31:0] exp_pc;
    logic [31:0] pend_a;
    bit          pend;
    int          fetched;
    logic [31:0] last_dlv;

    // SRAM responder state
    bit          outst;
    logic [31:0] out_addr;
    int          cnt;
    bit          acc;
    logic [31:0] acc_addr;

    bit                      prev_ce;
    bit                      prev_req;
    bit                      prev_acc;
    logic [`IF_TO_ID_WD-1:0] prev_bus;
    logic [31:0]             prev_inst;
    logic [31:0]             prev_addr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic model_reset();
        exp_pc   = RP;
        pend     = 1'b0;
        pend_a   = 32'd0;
        fetched  = 0;
        outst    = 1'b0;
        cnt      = 0;
        acc      = 1'b0;
        prev_ce  = 1'b0;
        prev_req = 1'b0;
        prev_acc = 1'b0;
        last_dlv = 32'd0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst               = 1'b1;
        stall             = '0;
        br_bus            = '0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'd0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one cycle: observe at negedge, check, then drive the next cycle's inputs
    task automatic step(input bit br, input logic [31:0] ba, input bit stop,
                        input bit acc_en, input int lat);
        bit ce;
        bit leave;
        @(negedge clk);
        ce = (if_to_id_bus[32] === 1'b1);

        n_chk++;
        if (stallreq_if !== !ce) begin
            n_fail++;
            $display("FAIL stallreq: got %b want %b", stallreq_if, !ce);
        end
        if (ce && !prev_ce) begin
            last_dlv = if_to_id_bus[31:0];
            n_chk++;
            if (if_to_id_bus[31:0] !== exp_pc) begin
                n_fail++;
                $display("FAIL deliver_pc: got %h want %h",
                         if_to_id_bus[31:0], exp_pc);
            end
            n_chk++;
            if (inst_o !== mem(exp_pc)) begin
                n_fail++;
                $display("FAIL deliver_inst: got %h want %h",
                         inst_o, mem(exp_pc));
            end
        end
        if (ce && prev_ce) begin
            n_chk++;
            if (if_to_id_bus !== prev_bus || inst_o !== prev_inst) begin
                n_fail++;
                $display("FAIL hold_stable: got %h/%h want %h/%h",
                         if_to_id_bus, inst_o, prev_bus, prev_inst);
            end
        end
        if (prev_req && !prev_acc) begin
            n_chk++;
            if (inst_sram_req !== 1'b1 || inst_sram_addr !== prev_addr) begin
                n_fail++;
                $display("FAIL req_stable: got %b/%h want 1/%h",
                         inst_sram_req, inst_sram_addr, prev_addr);
            end
        end
        if (ce && inst_sram_req !== 1'b0) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_in_hold: got %b want 0", inst_sram_req);
        end

        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = $urandom;
        acc               = 1'b0;
        if (outst) begin
            if (cnt == 0) begin
                inst_sram_data_ok = 1'b1;
                inst_sram_rdata   = mem(out_addr);
                outst             = 1'b0;
            end else begin
                cnt--;
            end
        end else begin
            inst_sram_data_ok = ($urandom % 4 == 0);
            if (inst_sram_req === 1'b1 && acc_en) begin
                acc               = 1'b1;
                acc_addr          = inst_sram_addr;
                inst_sram_addr_ok = 1'b1;
                outst             = 1'b1;
                out_addr          = inst_sram_addr;
                cnt               = lat;
                n_chk++;
                if (inst_sram_addr !== exp_pc) begin
                    n_fail++;
                    $display("FAIL fetch_addr: got %h want %h",
                             inst_sram_addr, exp_pc);
                end
            end
        end

        stall  = {{(`StallBus-1){1'b0}}, stop ? `Stop : `NoStop};
        br_bus = {br, ba};
        leave  = ce && !stop;
        if (leave) begin
            fetched++;
            if (br) exp_pc = ba;
            else if (pend) exp_pc = pend_a;
            else exp_pc = exp_pc + 32'd4;
            pend = 1'b0;
        end else if (br) begin
            pend   = 1'b1;
            pend_a = ba;
        end

        prev_ce   = ce;
        prev_req  = (inst_sram_req === 1'b1);
        prev_acc  = acc;
        prev_bus  = if_to_id_bus;
        prev_inst = inst_o;
        prev_addr = inst_sram_addr;
    endtask

    task automatic run_until_acc(output logic [31:0] a);
        a = 32'hxxxx_xxxx;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b1, 0);
            if (acc) begin
                a = acc_addr;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL acc_timeout: got none want accept within 40 cycles");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = '0;
        br_bus = '0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if (inst_sram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req: got %b want 0", inst_sram_req);
        end
        n_chk++;
        if (if_to_id_bus !== '0) begin
            n_fail++;
            $display("FAIL rst_bus: got %h want 0", if_to_id_bus);
        end
        n_chk++;
        if (stallreq_if !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_stallreq: got %b want 1", stallreq_if);
        end
        n_chk++;
        if (dut.pc_r !== RP || dut.inst_buf !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_regs: got %h/%h want %h/0",
                     dut.pc_r, dut.inst_buf, RP);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        step(1'b0, 32'd0, 1'b0, 1'b1, 0);
        n_chk++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== RP) begin
            n_fail++;
            $display("FAIL first_req: got %b/%h want 1/%h",
                     inst_sram_req, inst_sram_addr, RP);
        end
        step(1'b0, 32'd0, 1'b0, 1'b1, 0);
        n_chk++;
        if (if_to_id_bus[32] !== 1'b0) begin
            n_fail++;
            $display("FAIL first_wait_ce: got %b want 0", if_to_id_bus[32]);
        end
        step(1'b0, 32'd0, 1'b0, 1'b1, 0);
        n_chk++;
        if (if_to_id_bus !== {1'b1, RP}) begin
            n_fail++;
            $display("FAIL first_ce: got %h want %h", if_to_id_bus, {1'b1, RP});
        end
        step(1'b0, 32'd0, 1'b0, 1'b1, 0);
        n_chk++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== RP + 32'd4) begin
            n_fail++;
            $display("FAIL second_req: got %b/%h want 1/%h",
                     inst_sram_req, inst_sram_addr, RP + 32'd4);
        end
    endtask

    task automatic test_stall();
        logic [`IF_TO_ID_WD-1:0] bus0;
        logic [31:0] inst0;
        logic [31:0] a;
        reset_dut();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b1, 0);
            if (if_to_id_bus[32] === 1'b1) break;
        end
        bus0  = if_to_id_bus;
        inst0 = inst_o;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b1, 0);
            n_chk++;
            if (if_to_id_bus !== bus0 || inst_o !== inst0 || bus0[32] !== 1'b1
                || inst_sram_req !== 1'b0 || dut.pc_r !== RP) begin
                n_fail++;
                $display("FAIL stall_hold: got %h/%h/%b/%h want %h/%h/0/%h",
                         if_to_id_bus, inst_o, inst_sram_req, dut.pc_r,
                         {1'b1, RP}, inst0, RP);
            end
        end
        step(1'b0, 32'd0, 1'b0, 1'b1, 0);
        run_until_acc(a);
        n_chk++;
        if (a !== RP + 32'd4) begin
            n_fail++;
            $display("FAIL stall_next: got %h want %h", a, RP + 32'd4);
        end
    endtask

    task automatic test_branch_wait();
        logic [31:0] a;
        reset_dut();
        run_until_acc(a);
        step(1'b1, 32'hBFC0_0100, 1'b0, 1'b1, 0);
        run_until_acc(a);
        n_chk++;
        if (last_dlv !== RP) begin
            n_fail++;
            $display("FAIL delay_slot: got %h want %h", last_dlv, RP);
        end
        n_chk++;
        if (a !== 32'hBFC0_0100) begin
            n_fail++;
            $display("FAIL br_target: got %h want bfc00100", a);
        end
        run_until_acc(a);
        n_chk++;
        if (a !== 32'hBFC0_0104) begin
            n_fail++;
            $display("FAIL br_pend_clear: got %h want bfc00104", a);
        end
    endtask

    task automatic test_two_branches();
        logic [31:0] a;
        reset_dut();
        run_until_acc(a);
        step(1'b1, 32'hBFC0_0100, 1'b0, 1'b1, 0);
        step(1'b1, 32'hBFC0_0200, 1'b1, 1'b1, 0);
        n_chk++;
        if (if_to_id_bus[32] !== 1'b1) begin
            n_fail++;
            $display("FAIL two_br_hold: got %b want 1", if_to_id_bus[32]);
        end
        step(1'b0, 32'd0, 1'b0, 1'b1, 0);
        run_until_acc(a);
        n_chk++;
        if (a !== 32'hBFC0_0200) begin
            n_fail++;
            $display("FAIL two_br_target: got %h want bfc00200", a);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        reset_dut();
        run_until_acc(a);
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 0);
        run_until_acc(a);
        n_chk++;
        if (a !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_target: got %h want fffffffc", a);
        end
        run_until_acc(a);
        n_chk++;
        if (a !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: got %h want 00000000", a);
        end
    endtask

    task automatic test_addr_ok_hold();
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b0, 0);
            n_chk++;
            if (inst_sram_req !== 1'b1 || inst_sram_addr !== RP
                || stallreq_if !== 1'b1) begin
                n_fail++;
                $display("FAIL addr_ok_wait: got %b/%h/%b want 1/%h/1",
                         inst_sram_req, inst_sram_addr, stallreq_if, RP);
            end
        end
        step(1'b0, 32'd0, 1'b0, 1'b1, 20);
        step(1'b1, 32'hBFC0_0300, 1'b0, 1'b1, 20);
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (inst_sram_req !== 1'b0 || if_to_id_bus !== '0
            || stallreq_if !== 1'b1 || inst_o !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_wait: got %b/%h/%b/%h want 0/0/1/0",
                     inst_sram_req, if_to_id_bus, stallreq_if, inst_o);
        end
        n_chk++;
        if (dut.br_pend_v !== 1'b0 || dut.pc_r !== RP) begin
            n_fail++;
            $display("FAIL rst_mid_regs: got %b/%h want 0/%h",
                     dut.br_pend_v, dut.pc_r, RP);
        end
        model_reset();
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        br_bus = '0;
        @(negedge clk);
        rst = 1'b0;
        test_first_fetch();
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 8) == 0, RP + (($urandom % 64) * 4),
                 ($urandom % 3) == 0, ($urandom % 4) != 0,
                 int'($urandom % 3));
        end
        n_chk++;
        if (fetched < 40) begin
            n_fail++;
            $display("FAIL random_progress: got %0d want >=40", fetched);
        end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        reset_dut();
        for (int i = 0; i < 100 && fetched < 10; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b1, 0);
        end
        step(1'b0, 32'd0, 1'b1, 1'b1, 0);
        n_chk++;
        if (perf_fetch_cnt !== 32'd10) begin
            n_fail++;
            $display("FAIL perf_fetch: got %0d want 10", perf_fetch_cnt);
        end
    endtask
`endif

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch_wait();
        test_two_branches();
        test_wrap();
        test_addr_ok_hold();
        test_random();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
